// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light controller: FSM encoding,
// light patterns, display slot indices and small helper functions.
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_G  = 3'd0,
        NS_Y  = 3'd1,
        EW_G  = 3'd2,
        EW_Y  = 3'd3,
        ALL_R = 3'd4
    } state_t;

    // Light patterns, ordered {red, yellow, green}
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    // Display slot indices (also the bit position in the digit enable)
    localparam logic [1:0] SLOT_NS_U = 2'd0;
    localparam logic [1:0] SLOT_NS_T = 2'd1;
    localparam logic [1:0] SLOT_EW_U = 2'd2;
    localparam logic [1:0] SLOT_EW_T = 2'd3;

    // Successor in the normal NS_G -> NS_Y -> EW_G -> EW_Y loop
    function automatic state_t next_phase(input state_t s);
        case (s)
            NS_G:    next_phase = NS_Y;
            NS_Y:    next_phase = EW_G;
            EW_G:    next_phase = EW_Y;
            default: next_phase = NS_G;
        endcase
    endfunction

    // Displayed values never exceed 99, so a 4-bit quotient is enough
    function automatic logic [3:0] bcd_tens(input logic [6:0] v);
        bcd_tens = 4'(v / 7'd10);
    endfunction

    function automatic logic [3:0] bcd_units(input logic [6:0] v);
        bcd_units = 4'(v % 7'd10);
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_disp_scan.sv
// Four-digit multiplexed display scanner. Rotates through the slots at a
// fixed rate, regardless of the controller's enable or emergency state.
module disp_scan
    import traffic_pkg::*;
#(
    parameter int         SCAN_DIV  = 50000,
    parameter logic [3:0] RST_DIGIT = 4'd0
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic [3:0] ns_units,
    input  logic [3:0] ns_tens,
    input  logic [3:0] ew_units,
    input  logic [3:0] ew_tens,
    output logic [3:0] oDIGIT,
    output logic [3:0] oDIG_SEL
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

    logic [SW-1:0] scan_cnt_reg, scan_cnt_next;
    logic [1:0]    slot_reg, slot_next;
    logic [3:0]    digit_reg, digit_next;
    logic [3:0]    sel_reg, sel_next;

    // Slot timer and slot index; the value/enable pair is computed from
    // the upcoming slot so both registers flip together on one edge
    always_comb begin
        scan_cnt_next = scan_cnt_reg + 1'b1;
        slot_next     = slot_reg;
        if (scan_cnt_reg == SCAN_MAX) begin
            scan_cnt_next = '0;
            slot_next     = slot_reg + 2'd1;
        end
    end

    // Digit value for the upcoming slot
    always_comb begin
        digit_next = ns_units;
        case (slot_next)
            SLOT_NS_U: digit_next = ns_units;
            SLOT_NS_T: digit_next = ns_tens;
            SLOT_EW_U: digit_next = ew_units;
            SLOT_EW_T: digit_next = ew_tens;
            default:   digit_next = ns_units;
        endcase
    end

    // Active-low one-hot enable decode
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sel
            assign sel_next[gi] = (slot_next != 2'(gi));
        end
    endgenerate

    // Scan state and registered display outputs
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            scan_cnt_reg <= '0;
            slot_reg     <= SLOT_NS_U;
            digit_reg    <= RST_DIGIT;
            sel_reg      <= 4'b1110;
        end else begin
            scan_cnt_reg <= scan_cnt_next;
            slot_reg     <= slot_next;
            digit_reg    <= digit_next;
            sel_reg      <= sel_next;
        end
    end

    assign oDIGIT   = digit_reg;
    assign oDIG_SEL = sel_reg;

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-way intersection controller: phase FSM, one-second prescaler,
// per-phase countdown and countdown display for both directions.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int TICK_DIV = 50000000,
    parameter int SCAN_DIV = 50000,
    parameter int GREEN_S  = 25,
    parameter int YELLOW_S = 5
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iEN,
    input  logic       iEMERG,
    output logic [2:0] oLIGHT_NS,
    output logic [2:0] oLIGHT_EW,
    output logic [3:0] oDIGIT,
    output logic [3:0] oDIG_SEL
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [6:0] GREEN_LEN  = 7'(GREEN_S);
    localparam logic [6:0] YELLOW_LEN = 7'(YELLOW_S);
    localparam logic [3:0] RST_UNITS  = 4'(GREEN_S % 10);

    state_t        state_reg, state_next;
    logic [6:0]    cnt_reg, cnt_next;
    logic [PW-1:0] presc_reg, presc_next;
    logic          tick;
    logic [6:0]    ns_val, ew_val;

    // One-cycle tick on the prescaler wrap; only while running normally
    assign tick = iEN && (state_reg != ALL_R) && (presc_reg == PRESC_MAX);

    // Next-state, countdown and prescaler; emergency takes priority over all
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        presc_next = presc_reg;
        if (iEMERG) begin
            state_next = ALL_R;
            cnt_next   = '0;
            presc_next = '0;
        end else if (state_reg == ALL_R) begin
            state_next = NS_G;
            cnt_next   = GREEN_LEN;
            presc_next = '0;
        end else if (iEN) begin
            presc_next = tick ? '0 : presc_reg + 1'b1;
            if (tick) begin
                if (cnt_reg == 7'd1) begin
                    state_next = next_phase(state_reg);
                    cnt_next   = (state_reg == NS_G || state_reg == EW_G)
                                 ? YELLOW_LEN : GREEN_LEN;
                end else begin
                    cnt_next = cnt_reg - 7'd1;
                end
            end
        end
    end

    // FSM, countdown and prescaler registers
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_reg <= NS_G;
            cnt_reg   <= GREEN_LEN;
            presc_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            presc_reg <= presc_next;
        end
    end

    // Lights and per-direction seconds-to-change, decoded from the phase
    always_comb begin
        oLIGHT_NS = RED;
        oLIGHT_EW = RED;
        ns_val    = '0;
        ew_val    = '0;
        case (state_reg)
            NS_G: begin
                oLIGHT_NS = GRN;
                ns_val    = cnt_reg;
                ew_val    = cnt_reg + YELLOW_LEN;
            end
            NS_Y: begin
                oLIGHT_NS = YEL;
                ns_val    = cnt_reg;
                ew_val    = cnt_reg;
            end
            EW_G: begin
                oLIGHT_EW = GRN;
                ns_val    = cnt_reg + YELLOW_LEN;
                ew_val    = cnt_reg;
            end
            EW_Y: begin
                oLIGHT_EW = YEL;
                ns_val    = cnt_reg;
                ew_val    = cnt_reg;
            end
            default: begin
                ns_val = '0;
                ew_val = '0;
            end
        endcase
    end

    disp_scan #(
        .SCAN_DIV  (SCAN_DIV),
        .RST_DIGIT (RST_UNITS)
    ) u_scan (
        .iCLK     (iCLK),
        .iRST_N   (iRST_N),
        .ns_units (bcd_units(ns_val)),
        .ns_tens  (bcd_tens(ns_val)),
        .ew_units (bcd_units(ew_val)),
        .ew_tens  (bcd_tens(ew_val)),
        .oDIGIT   (oDIGIT),
        .oDIG_SEL (oDIG_SEL)
    );

endmodule
